// File: rtl/snake_pkg.sv
// Shared definitions for the snake food placement logic.
//   - food_state_e : placement FSM states
//   - coord_t      : 11-bit screen coordinate
//   - arena origin, fallback cell and LFSR seed/taps
//   - lfsr16_next  : one step of the 16-bit Fibonacci LFSR
package snake_pkg;

    typedef logic [10:0] coord_t;

    typedef enum logic [1:0] {
        StIdle,
        StGen,
        StQuery,
        StCommit
    } food_state_e;

    // Arena is 256x256 cells anchored at (ArenaLeft, ArenaTop).
    localparam int unsigned ArenaLeft = 212;
    localparam int unsigned ArenaTop  = 112;
    localparam int unsigned FallbackX = 340;
    localparam int unsigned FallbackY = 240;

    localparam logic [15:0] LfsrSeed = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LfsrTaps = 16'hB400;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {s[14:0], ^(s & LfsrTaps)};
    endfunction

endpackage

// File: rtl/snake_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the food position source.
// Ports:
//   Clock  - system clock, rising edge
//   Reset  - synchronous, active-high; loads LfsrSeed
//   oLfsr  - current LFSR state (never zero)
module snake_lfsr16
    import snake_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] oLfsr
);

    logic [15:0] lfsr_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= lfsr16_next(lfsr_q);
        end
    end

    assign oLfsr = lfsr_q;

endmodule

// File: rtl/snake_food_ctrl.sv
// Food placement controller for the snake game.
// Picks a pseudo-random cell inside the 256x256 arena, asks the snake body whether the cell is
// occupied, retries up to MAX_TRY times and falls back to (FALLBACK_X, FALLBACK_Y) if every
// attempt collides.
// Optional feature: define SNAKE_FOOD_TIMEOUT_EN to relocate food that has not been eaten within
// TIMEOUT_FRAMES frames; without it iFrameTick is unused.
// Ports:
//   Clock, Reset                   - clock, synchronous active-high reset
//   iEaten                         - pulse, head reached food (honoured only in IDLE)
//   iGameOver                      - level, halts placement; falling edge places fresh food
//   iFrameTick                     - pulse per video frame (timeout build only)
//   oQueryValid, oQueryX, oQueryY  - occupancy query to the snake body
//   iQueryDone, iQueryHit          - query response
//   oFoodLocationX/Y, oFoodValid   - committed food cell and its visibility
//   oBusy, oTryCount               - placement in progress, attempts used
module snake_food_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned LIM_H_IZQ      = ArenaLeft,
    parameter int unsigned LIM_V_UP       = ArenaTop,
    parameter int unsigned MAX_TRY        = 15,
    parameter int unsigned FALLBACK_X     = FallbackX,
    parameter int unsigned FALLBACK_Y     = FallbackY,
    parameter int unsigned TIMEOUT_FRAMES = 600
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         iEaten,
    input  logic         iGameOver,
    input  logic         iFrameTick,
    output logic         oQueryValid,
    output logic [10:0]  oQueryX,
    output logic [10:0]  oQueryY,
    input  logic         iQueryDone,
    input  logic         iQueryHit,
    output logic [10:0]  oFoodLocationX,
    output logic [10:0]  oFoodLocationY,
    output logic         oFoodValid,
    output logic         oBusy,
    output logic [3:0]   oTryCount
);

    localparam coord_t     OriginX = coord_t'(LIM_H_IZQ);
    localparam coord_t     OriginY = coord_t'(LIM_V_UP);
    localparam coord_t     FbX     = coord_t'(FALLBACK_X);
    localparam coord_t     FbY     = coord_t'(FALLBACK_Y);
    localparam logic [3:0] MaxTry  = 4'(MAX_TRY);

    food_state_e state_q, state_d;
    coord_t      query_x_q, query_x_d;
    coord_t      query_y_q, query_y_d;
    coord_t      food_x_q, food_x_d;
    coord_t      food_y_q, food_y_d;
    logic        valid_q, valid_d;
    logic [3:0]  try_q, try_d;
    logic        fallback_q, fallback_d;
    logic        game_over_q;
    logic [15:0] lfsr;

`ifdef SNAKE_FOOD_TIMEOUT_EN
    localparam logic [15:0] FrameLast = 16'(TIMEOUT_FRAMES - 1);
    logic [15:0] frame_q, frame_d;
`else
    logic unused_tick;
    assign unused_tick = iFrameTick ^ (TIMEOUT_FRAMES == 0);
`endif

    snake_lfsr16 u_lfsr (
        .Clock (Clock),
        .Reset (Reset),
        .oLfsr (lfsr)
    );

    always_comb begin
        state_d    = state_q;
        query_x_d  = query_x_q;
        query_y_d  = query_y_q;
        food_x_d   = food_x_q;
        food_y_d   = food_y_q;
        valid_d    = valid_q;
        try_d      = try_q;
        fallback_d = fallback_q;
`ifdef SNAKE_FOOD_TIMEOUT_EN
        frame_d    = frame_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (iEaten) begin
                    valid_d = 1'b0;
                    state_d = StGen;
                end
`ifdef SNAKE_FOOD_TIMEOUT_EN
                else if (valid_q && iFrameTick) begin
                    if (frame_q == FrameLast) begin
                        valid_d = 1'b0;
                        frame_d = '0;
                        state_d = StGen;
                    end else begin
                        frame_d = frame_q + 16'd1;
                    end
                end
`endif
            end
            StGen: begin
                // Zero-extended 8-bit offsets keep candidates inside the 256x256 arena.
                query_x_d = OriginX + coord_t'(lfsr[7:0]);
                query_y_d = OriginY + coord_t'(lfsr[15:8]);
                try_d     = try_q + 4'd1;
                state_d   = StQuery;
            end
            StQuery: begin
                if (iQueryDone) begin
                    if (iQueryHit && (try_q < MaxTry)) begin
                        state_d = StGen;
                    end else begin
                        fallback_d = iQueryHit;
                        state_d    = StCommit;
                    end
                end
            end
            StCommit: begin
                food_x_d = fallback_q ? FbX : query_x_q;
                food_y_d = fallback_q ? FbY : query_y_q;
                valid_d  = 1'b1;
                try_d    = '0;
                state_d  = StIdle;
`ifdef SNAKE_FOOD_TIMEOUT_EN
                frame_d  = '0;
`endif
            end
            default: state_d = StIdle;
        endcase

`ifdef SNAKE_FOOD_TIMEOUT_EN
        if (iEaten) begin
            frame_d = '0;
        end
`endif

        // Fresh food once the game resumes.
        if (game_over_q && !iGameOver) begin
            state_d = StGen;
        end

        // Game over wins over every other event in the same cycle; location is kept.
        if (iGameOver) begin
            state_d = StIdle;
            valid_d = 1'b0;
            try_d   = '0;
`ifdef SNAKE_FOOD_TIMEOUT_EN
            frame_d = '0;
`endif
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= StGen;
            query_x_q   <= '0;
            query_y_q   <= '0;
            food_x_q    <= FbX;
            food_y_q    <= FbY;
            valid_q     <= 1'b0;
            try_q       <= '0;
            fallback_q  <= 1'b0;
            game_over_q <= 1'b0;
`ifdef SNAKE_FOOD_TIMEOUT_EN
            frame_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            query_x_q   <= query_x_d;
            query_y_q   <= query_y_d;
            food_x_q    <= food_x_d;
            food_y_q    <= food_y_d;
            valid_q     <= valid_d;
            try_q       <= try_d;
            fallback_q  <= fallback_d;
            game_over_q <= iGameOver;
`ifdef SNAKE_FOOD_TIMEOUT_EN
            frame_q     <= frame_d;
`endif
        end
    end

    assign oQueryValid    = (state_q == StQuery);
    assign oQueryX        = query_x_q;
    assign oQueryY        = query_y_q;
    assign oFoodLocationX = food_x_q;
    assign oFoodLocationY = food_y_q;
    assign oFoodValid     = valid_q;
    assign oBusy          = (state_q != StIdle);
    assign oTryCount      = try_q;

endmodule

// File: doc/snake_food_ctrl.md
SNAKE_FOOD_CTRL -- requirements
Module: snake_food_ctrl

Interface
REQ-001 SHALL have parameters: LIM_H_IZQ, 212, arena left column; LIM_V_UP, 112, arena top row; MAX_TRY, 15, placement attempts before fallback; FALLBACK_X, 340, fallback column; FALLBACK_Y, 240, fallback row; TIMEOUT_FRAMES, 600, frames before forced relocation.
REQ-002 Clock  in  1  system clock; all logic on rising edge.
REQ-003 Reset  in  1  synchronous, active-high.
REQ-004 iEaten  in  1  one-cycle pulse: snake head reached food.
REQ-005 iGameOver  in  1  level: game halted.
REQ-006 iFrameTick  in  1  one-cycle pulse per video frame.
REQ-007 oQueryValid  out  1  occupancy query request to snake body.
REQ-008 oQueryX / oQueryY  out  11 each  candidate cell, stable while oQueryValid=1.
REQ-009 iQueryDone  in  1  one-cycle pulse: query answered.
REQ-010 iQueryHit  in  1  candidate is occupied; valid only when iQueryDone=1.
REQ-011 oFoodLocationX / oFoodLocationY  out  11 each  committed food cell.
REQ-012 oFoodValid  out  1  food displayed and edible.
REQ-013 oBusy  out  1  placement in progress (state not IDLE).
REQ-014 oTryCount  out  4  attempts used in current placement.

Function
REQ-015 SHALL run FSM IDLE, GEN, QUERY, COMMIT.
REQ-016 SHALL advance a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) every cycle, never reaching zero.
REQ-017 GEN (1 cycle): oQueryX = LIM_H_IZQ + lfsr[7:0], oQueryY = LIM_V_UP + lfsr[15:8], zero-extended to 11 bits; oTryCount increments; next QUERY.
REQ-018 QUERY: oQueryValid=1, candidate held; on iQueryDone: hit and oTryCount<MAX_TRY -> GEN; hit and oTryCount==MAX_TRY -> COMMIT with fallback; no hit -> COMMIT with candidate.
REQ-019 COMMIT (1 cycle): load oFoodLocationX/Y, set oFoodValid=1 the next cycle, clear oTryCount, go IDLE.
REQ-020 IDLE: iEaten=1 -> clear oFoodValid next cycle, go GEN; iEaten while not IDLE SHALL be ignored.
REQ-021 Candidates SHALL always lie in 212..467 x 112..367 (256x256 arena).
REQ-022 iGameOver=1 in any state SHALL force IDLE, oFoodValid=0, oQueryValid=0 next cycle; location held; takes priority over iEaten and iQueryDone in same cycle.
REQ-023 On iGameOver falling, SHALL go GEN to place fresh food.
REQ-024 iQueryDone outside QUERY SHALL be ignored.
REQ-025 Latency eat-to-valid with no hit SHALL be 4 cycles after iQueryDone response (GEN, QUERY, COMMIT, valid).

Reset
REQ-026 Reset SHALL set state GEN, oFoodLocationX=FALLBACK_X, oFoodLocationY=FALLBACK_Y, oFoodValid=0, oQueryValid=0, oTryCount=0, LFSR=seed, timeout counter=0.
REQ-027 Reset mid-placement SHALL abort without commit; placement restarts from GEN after release.

Configuration
REQ-028 Macro SNAKE_FOOD_TIMEOUT_EN defined: frame counter counts iFrameTick while IDLE and oFoodValid=1; at TIMEOUT_FRAMES clears oFoodValid and goes GEN; cleared on commit, iEaten, iGameOver.
REQ-029 Macro undefined: no counter; food persists until eaten; iFrameTick unused.

Structure
REQ-030 Shared package snake_pkg SHALL hold FSM state typedef, arena limits, LFSR seed/taps, 11-bit coordinate typedef.
REQ-031 Sub-module snake_lfsr16 (free-running LFSR, sync reset to seed) SHALL be instantiated once.

Verification
REQ-032 Reset release, responder answers hit=0 after 2 cycles -> first candidate from LFSR state after reset, oFoodValid=1, oTryCount back to 0.
REQ-033 Responder hit=1 on all queries -> 15 queries, commit (340,240), oFoodValid=1.
REQ-034 Hit=1 for 3 queries then 0 -> 4th candidate committed, oTryCount reached 4.
REQ-035 iEaten and iGameOver same cycle in IDLE -> oFoodValid=0, state IDLE, no query issued.
REQ-036 iEaten during QUERY -> ignored; placement completes normally.
REQ-037 SNAKE_FOOD_TIMEOUT_EN, TIMEOUT_FRAMES=4, no eat -> 4 ticks after valid, oFoodValid=0 and new query raised.
